// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream_mux_rr multiplexer: mode encodings and FSM states.
package stream_mux_rr_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Round-robin picker: first requesting index strictly after ptr, wrapping modulo NUM_CH.
module stream_mux_rr_pick
    import stream_mux_rr_pkg::*;
#(
    parameter int unsigned  NUM_CH = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    logic [NUM_CH-1:0] rot;
    logic [SEL_W-1:0]  src;
    int unsigned       off;

    // Rotate so bit 0 is the channel after ptr, priority-encode, then rotate back.
    always_comb begin
        rot = '0;
        src = '0;
        off = 0;
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            src    = SEL_W'((32'(ptr) + 32'd1 + j) % NUM_CH);
            rot[j] = req[src];
        end
        for (int unsigned j = NUM_CH; j > 0; j--) begin
            if (rot[j-1]) begin
                off = j - 1;
            end
        end
        gnt_idx = SEL_W'((32'(ptr) + 32'd1 + off) % NUM_CH);
        gnt_any = |req;
    end

endmodule

// File: rtl/stream_mux_rr.sv
// NUM_CH:1 packet-aware stream multiplexer with select or round-robin arbitration
// and a registered output stage.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int unsigned  NUM_CH = 4,
    parameter int unsigned  DATA_W = 8,
    localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic [SEL_W-1:0]  cand;
    logic              cand_ok;
    logic              load_en;
    logic              xfer;
    logic [DATA_W-1:0] mux_data;
    logic              mux_last;

    assign load_en = !out_valid || out_ready;

    stream_mux_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Candidate channel: the lock holder wins; otherwise select or round-robin.
    always_comb begin
        cand    = lock_ch_q;
        cand_ok = 1'b1;
        if (state_q == ST_IDLE) begin
            if (mode == MODE_RR) begin
                cand    = pick_idx;
                cand_ok = pick_any;
            end else begin
                cand    = sel;
                cand_ok = (32'(sel) < NUM_CH);
            end
        end
    end

    // One-hot ready decode and the matching data/last mux.
    always_comb begin
        in_ready = '0;
        mux_data = '0;
        mux_last = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(cand) == i) begin
                in_ready[i] = !reset && load_en && cand_ok;
                mux_data    = in_data[i*DATA_W +: DATA_W];
                mux_last    = in_last[i];
            end
        end
        xfer = |(in_valid & in_ready);
    end

    // Packet lock: hold the channel until its last beat transfers.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (mux_last) begin
                        rr_ptr_d = cand;
                    end else begin
                        state_d   = ST_LOCKED;
                        lock_ch_d = cand;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer && mux_last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = lock_ch_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lock_ch_q <= '0;
            rr_ptr_q  <= SEL_W'(NUM_CH - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            rr_ptr_q  <= rr_ptr_d;
            if (load_en) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= mux_data;
                    out_last <= mux_last;
                    out_ch   <= cand;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed, table-driven bench for stream_mux_rr (4-channel and 3-channel instances).
module tb_stream_mux_rr;

    localparam int unsigned NV = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_last3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_last3;
    logic [1:0]  out_ch3;
    logic        out_ready3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  erdy;
        logic        ev;
        logic [7:0]  ed;
        logic [1:0]  ech;
        logic        el;
    } vec_t;

    vec_t vecs[NV];

    stream_mux_rr #(.NUM_CH(4), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    stream_mux_rr #(.NUM_CH(3), .DATA_W(8)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_last   (in_last3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_last  (out_last3),
        .out_ch    (out_ch3),
        .out_ready (out_ready3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v,
                                input logic [3:0] l, input logic [31:0] d, input logic r,
                                input logic [3:0] erdy, input logic ev, input logic [7:0] ed,
                                input logic [1:0] ech, input logic el);
        vec_t t;
        t.mode = m;  t.sel = s;   t.valid = v; t.last = l; t.data = d; t.ordy = r;
        t.erdy = erdy; t.ev = ev; t.ed = ed;   t.ech = ech; t.el = el;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Round-robin over four single-beat sources, starting at ch0.
        vecs[0]  = mk(1'b1, 2'd0, 4'b1111, 4'b1111, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1);
        vecs[1]  = mk(1'b1, 2'd0, 4'b1111, 4'b1111, 32'h44332211, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1);
        vecs[2]  = mk(1'b1, 2'd0, 4'b1111, 4'b1111, 32'h44332211, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2, 1'b1);
        vecs[3]  = mk(1'b1, 2'd0, 4'b1111, 4'b1111, 32'h44332211, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1);
        vecs[4]  = mk(1'b1, 2'd0, 4'b1111, 4'b1111, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1);
        // Select mode: ch2 single beat, then ch2 idle.
        vecs[5]  = mk(1'b0, 2'd2, 4'b0100, 4'b0100, 32'h44A52211, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1);
        vecs[6]  = mk(1'b0, 2'd2, 4'b1011, 4'b1111, 32'h44A52211, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0, 1'b0);
        // Three-beat packet on ch1 with a gap; ch0/ch3 compete but stay out.
        vecs[7]  = mk(1'b0, 2'd1, 4'b0010, 4'b0000, 32'h44335A11, 1'b1, 4'b0010, 1'b1, 8'h5A, 2'd1, 1'b0);
        vecs[8]  = mk(1'b0, 2'd3, 4'b1010, 4'b0000, 32'h44335B11, 1'b1, 4'b0010, 1'b1, 8'h5B, 2'd1, 1'b0);
        vecs[9]  = mk(1'b1, 2'd0, 4'b1001, 4'b1001, 32'h44335B11, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[10] = mk(1'b1, 2'd0, 4'b1011, 4'b0010, 32'h44335C11, 1'b1, 4'b0010, 1'b1, 8'h5C, 2'd1, 1'b1);
        vecs[11] = mk(1'b1, 2'd0, 4'b1001, 4'b1001, 32'h44335C11, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1);
        vecs[12] = mk(1'b1, 2'd0, 4'b0001, 4'b0001, 32'h44335C11, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1);
        vecs[13] = mk(1'b1, 2'd0, 4'b0000, 4'b0000, 32'h44335C11, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);

        reset = 1'b1; mode = 1'b1; sel = 2'd0; in_data = 32'h44332211;
        in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; in_data3 = 24'h0; in_valid3 = 3'b000;
        in_last3 = 3'b000; out_ready3 = 1'b1;

        tick();
        chk("reset in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data", 32'(out_data), 32'h0);
        chk("reset out_last", 32'(out_last), 32'h0);
        chk("reset out_ch", 32'(out_ch), 32'h0);
        chk("reset out_valid3", 32'(out_valid3), 32'h0);
        reset = 1'b0;

        for (int k = 0; k < int'(NV); k++) begin
            mode = vecs[k].mode; sel = vecs[k].sel; in_valid = vecs[k].valid;
            in_last = vecs[k].last; in_data = vecs[k].data; out_ready = vecs[k].ordy;
            #1;
            chk($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(vecs[k].erdy));
            tick();
            chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vecs[k].ev));
            if (vecs[k].ev) begin
                chk($sformatf("v%0d out_data", k), 32'(out_data), 32'(vecs[k].ed));
                chk($sformatf("v%0d out_ch", k), 32'(out_ch), 32'(vecs[k].ech));
                chk($sformatf("v%0d out_last", k), 32'(out_last), 32'(vecs[k].el));
            end
        end

        // Backpressure: hold 0x3C for three stalled cycles, then 0x3D follows directly.
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_last = 4'b0001;
        in_data = 32'h0000003C; out_ready = 1'b1;
        #1;
        chk("bp first in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("bp first out_data", 32'(out_data), 32'h3C);
        in_data = 32'h0000003D; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp stall%0d in_ready", c), 32'(in_ready), 32'h0);
            tick();
            chk($sformatf("bp stall%0d out_valid", c), 32'(out_valid), 32'h1);
            chk($sformatf("bp stall%0d out_data", c), 32'(out_data), 32'h3C);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("bp release out_valid", 32'(out_valid), 32'h1);
        chk("bp release out_data", 32'(out_data), 32'h3D);
        in_valid = 4'b0000;
        tick();
        chk("bp drain out_valid", 32'(out_valid), 32'h0);

        // Reset while locked on ch2 drops the lock and the pending beat.
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_last = 4'b0000;
        in_data = 32'h00770000;
        tick();
        chk("lock out_ch", 32'(out_ch), 32'h2);
        chk("lock out_valid", 32'(out_valid), 32'h1);
        reset = 1'b1; mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
        in_data = 32'h44332211;
        #1;
        chk("rst lock in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("rst lock out_valid", 32'(out_valid), 32'h0);
        reset = 1'b0;
        #1;
        chk("post rst in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("post rst out_ch", 32'(out_ch), 32'h0);
        chk("post rst out_data", 32'(out_data), 32'h11);
        in_valid = 4'b0000;

        // Three-channel instance: out-of-range select grants nothing.
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_last3 = 3'b111;
        in_data3 = 24'hCCBBAA; out_ready3 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("n3 sel3 in_ready%0d", c), 32'(in_ready3), 32'h0);
            tick();
            chk($sformatf("n3 sel3 out_valid%0d", c), 32'(out_valid3), 32'h0);
        end
        sel3 = 2'd2;
        #1;
        chk("n3 sel2 in_ready", 32'(in_ready3), 32'h4);
        tick();
        chk("n3 sel2 out_valid", 32'(out_valid3), 32'h1);
        chk("n3 sel2 out_data", 32'(out_data3), 32'hCC);
        chk("n3 sel2 out_ch", 32'(out_ch3), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the team's 4:1 multiplexer: NUM_CH-input, DATA_W-wide stream multiplexer with valid/ready handshake on every port and a registered output.
- Two modes: explicit select, or round-robin arbitration across requesting channels.
- Packet-aware: once a channel is granted, it keeps the output until its `last` beat transfers.
- Sits between multiple producer streams and a single consumer.

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- DATA_W, 8, data width per channel.
- SEL_W, $clog2(NUM_CH), derived localparam; width of select/channel fields.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = select-driven, 1 = round-robin.
- sel  input  SEL_W  channel select, used only when mode=0.
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_last  input  NUM_CH  per-channel end-of-packet flag.
- in_ready  output  NUM_CH  per-channel ready, combinational.
- out_data  output  DATA_W  registered data.
- out_valid  output  1  registered valid.
- out_last  output  1  registered last.
- out_ch  output  SEL_W  source channel of the current out beat.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, out_ch=0, state=IDLE, rr_ptr=NUM_CH-1 (so channel 0 has first priority).
- Reset behaviour:
  - Reset mid-packet drops the lock and clears any pending out beat.
  - in_ready is all-zero during reset.
- Load condition: load_en = !out_valid || out_ready. The output register accepts a beat only when load_en=1.
- Grant selection:
  - IDLE, mode=0: cand = sel. If sel >= NUM_CH, there is no candidate.
  - IDLE, mode=1: cand = first channel with in_valid=1, searching upward from rr_ptr+1 modulo NUM_CH. If no channel is valid, there is no candidate.
  - LOCKED: cand = lock_ch. mode and sel are ignored.
- Handshake and transfer:
  - in_ready[i] = load_en && cand valid && (i == cand). All other bits are 0.
  - Transfer happens on in_valid[cand] && in_ready[cand].
  - On transfer at the clock edge: out_data, out_last and out_ch load from channel cand, and out_valid=1.
  - If load_en=1 and no transfer occurs, out_valid goes to 0.
  - If load_en=0, all output registers hold.
- FSM (IDLE, LOCKED):
  - IDLE: transfer with in_last=0 -> LOCKED, lock_ch=cand.
  - IDLE: transfer with in_last=1 -> stays IDLE (single-beat packet), rr_ptr=cand.
  - LOCKED: transfer with in_last=1 -> IDLE, rr_ptr=lock_ch.
  - LOCKED: any other cycle -> stays LOCKED.
  - A locked channel that deasserts in_valid mid-packet keeps the lock; no other channel is served.
- rr_ptr updates only on completion of a packet. It is updated in both modes, so switching to mode=1 resumes fairly.
- Timing: latency is 1 cycle from input transfer to out_valid. Sustained throughput is 1 beat/cycle while out_ready=1.
- Backpressure: with out_ready=0 and out_valid=1, in_ready is all-zero and the outputs are stable (AXI-stream-like rules).
- Simultaneous events: a new transfer and consumption of the current out beat in the same cycle are legal and give back-to-back beats.
- No combinational path from in_valid to out_*. The only combinational path is from out_ready, mode, sel and in_valid to in_ready.

Decomposition:
- Shared package: MODE_SEL=1'b0, MODE_RR=1'b1, and a state enum {ST_IDLE, ST_LOCKED}.
- Sub-module rr_pick:
  - Purely combinational; parametrised by NUM_CH.
  - Inputs: req[NUM_CH], ptr[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_any.
  - Implemented as a rotate, then priority-encode, then un-rotate.
- Top-level contents: FSM, output register and in_ready decode.

Test Plan:
- Reset, then mode=0, sel=2, ch2 sends 0xA5 with last=1, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ch=2, out_last=1. in_ready stays 0 for ch0, ch1 and ch3 throughout.
- mode=1, all 4 channels hold valid single-beat packets, out_ready=1 -> out_ch sequence 0,1,2,3,0,... with one beat per cycle.
- mode=1, ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch3 are valid -> out_ch=1 for 3 consecutive beats, then 3, then 0. ch1 deasserting valid for one cycle mid-packet does not let ch0 or ch3 in.
- out_ready held 0 for 3 cycles with out_valid=1, out_data=0x3C -> out_data stays 0x3C, in_ready=0000. On release, the next beat follows with no bubble.
- Reset asserted while LOCKED on ch2 -> next cycle out_valid=0, state=IDLE. In mode=1 the first grant after reset goes to ch0.
- NUM_CH=3 instance, mode=0, sel=3 -> in_ready=000, out_valid stays 0.
